// File: rtl/tournament_pkg.sv
// Shared types for the tournament predictor choice side: counter encoding,
// in-flight queue entry and the saturating counter step.
package tournament_pkg;

  // Widest history the in-flight entry can carry; the controller's HIST_BITS must not exceed it.
  localparam int unsigned HIST_W = 4;

  typedef enum logic [1:0] {
    STRONG_LOCAL  = 2'd0,
    WEAK_LOCAL    = 2'd1,
    WEAK_GLOBAL   = 2'd2,
    STRONG_GLOBAL = 2'd3
  } choice_e;

  localparam choice_e CHOICE_RESET = STRONG_LOCAL;

  typedef struct packed {
    logic [HIST_W-1:0] idx;
    logic              local_pred;
    logic              global_pred;
    logic              taken;
  } inflight_t;

  // One saturating step toward global (up) or toward local (down).
  function automatic choice_e choice_step(choice_e c, logic toward_global);
    if (toward_global) begin
      return (c == STRONG_GLOBAL) ? c : choice_e'(2'(c) + 2'd1);
    end
    return (c == STRONG_LOCAL) ? c : choice_e'(2'(c) - 2'd1);
  endfunction

endpackage

// File: rtl/inflight_fifo.sv
// In-order queue of in-flight branches; flush and reset empty it in one cycle.
module inflight_fifo
  import tournament_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  inflight_t                  din,
  output inflight_t                  dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  inflight_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  assign dout = mem[head];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail] <= din;
  end

endmodule

// File: rtl/tournament_choice_ctrl.sv
// Choice-side controller of the tournament predictor: single-ported choice table,
// flush > resolve > request arbitration, in-order resolve with non-speculative history.
module tournament_choice_ctrl
  import tournament_pkg::*;
#(
  parameter int unsigned HIST_BITS = HIST_W,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_local_pred,
  input  logic                     req_global_pred,
  output logic                     resp_valid,
  output logic                     resp_taken,
  output logic                     resp_use_global,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic [HIST_BITS-1:0]     ghist,
  output logic [$clog2(DEPTH):0]   inflight_cnt,
  output logic [CNT_W-1:0]         mispredict_cnt
);

  localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRIES = 2 ** HIST_BITS;

  choice_e              choice_tbl [ENTRIES];
  logic [1:0]           cur_choice;
  logic                 accept;
  logic                 resolve;
  logic                 use_global;
  logic                 pred_taken;
  logic [HIST_BITS-1:0] res_idx;
  inflight_t            push_entry;
  inflight_t            head_entry;

  assign req_ready  = !reset && !flush && !res_valid && (inflight_cnt != OCC_W'(DEPTH));
  assign res_ready  = !reset && (inflight_cnt != '0);
  assign accept     = req_valid && req_ready;
  assign resolve    = res_valid && res_ready && !flush;

  assign cur_choice = choice_tbl[ghist];
  assign use_global = cur_choice[1];
  assign pred_taken = use_global ? req_global_pred : req_local_pred;
  assign res_idx    = HIST_BITS'(head_entry.idx);

  assign push_entry = '{idx:         HIST_W'(ghist),
                        local_pred:  req_local_pred,
                        global_pred: req_global_pred,
                        taken:       pred_taken};

  inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (resolve),
    .flush (flush),
    .din   (push_entry),
    .dout  (head_entry),
    .count (inflight_cnt)
  );

  // Table update and history/mispredict bookkeeping happen only on a resolve edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) choice_tbl[i] <= CHOICE_RESET;
      ghist           <= '0;
      mispredict_cnt  <= '0;
      resp_valid      <= 1'b0;
      resp_taken      <= 1'b0;
      resp_use_global <= 1'b0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_taken      <= pred_taken;
        resp_use_global <= use_global;
      end
      if (resolve) begin
        if (head_entry.local_pred != head_entry.global_pred) begin
          choice_tbl[res_idx] <= choice_step(choice_tbl[res_idx],
                                             head_entry.global_pred == res_taken);
        end
        ghist <= {ghist[HIST_BITS-2:0], res_taken};
        if ((head_entry.taken != res_taken) && (mispredict_cnt != '1)) begin
          mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tournament_choice_ctrl.sv
// Bench for tournament_choice_ctrl: directed scenarios then random traffic,
// all checked against a queue-based reference model of the predictor.
module tb_tournament_choice_ctrl;

  localparam int HB    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_local_pred, req_global_pred;
  logic        resp_valid, resp_taken, resp_use_global;
  logic        res_valid, res_ready, res_taken, flush;
  logic [HB-1:0] ghist;
  logic [2:0]  inflight_cnt;
  logic [CW-1:0] mispredict_cnt;

  tournament_choice_ctrl #(.HIST_BITS(HB), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_local_pred  (req_local_pred),
    .req_global_pred (req_global_pred),
    .resp_valid      (resp_valid),
    .resp_taken      (resp_taken),
    .resp_use_global (resp_use_global),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_taken       (res_taken),
    .flush           (flush),
    .ghist           (ghist),
    .inflight_cnt    (inflight_cnt),
    .mispredict_cnt  (mispredict_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx;
    bit lp;
    bit gp;
    bit tk;
  } entry_t;

  int     m_tbl [16];
  int     m_ghist;
  int     m_miss;
  entry_t m_q[$];
  bit     m_rv, m_rt, m_ug;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_tbl[i]) m_tbl[i] = 0;
    m_ghist = 0;
    m_miss  = 0;
    m_q.delete();
    m_rv = 0; m_rt = 0; m_ug = 0;
  endtask

  // One clock: drive inputs, check ready flags, advance model, check registered outputs.
  task automatic step(input bit rst, input bit fl, input bit rv, input bit lp, input bit gp,
                      input bit resv, input bit rt);
    bit exp_req_ready, exp_res_ready, acc, res;
    entry_t e;
    reset = rst; flush = fl; req_valid = rv; req_local_pred = lp; req_global_pred = gp;
    res_valid = resv; res_taken = rt;
    #1;
    exp_req_ready = !rst && !fl && !resv && (m_q.size() != DEPTH);
    exp_res_ready = !rst && (m_q.size() != 0);
    check("req_ready", int'(req_ready), int'(exp_req_ready));
    check("res_ready", int'(res_ready), int'(exp_res_ready));
    if (rst) begin
      model_reset();
    end else begin
      acc  = rv && exp_req_ready;
      res  = resv && exp_res_ready && !fl;
      m_rv = acc;
      if (acc) begin
        e.idx = m_ghist;
        e.lp  = lp;
        e.gp  = gp;
        m_ug  = (m_tbl[m_ghist] >= 2);
        e.tk  = m_ug ? gp : lp;
        m_rt  = e.tk;
        m_q.push_back(e);
      end
      if (res) begin
        e = m_q.pop_front();
        if (e.lp != e.gp) begin
          if (e.gp == rt) m_tbl[e.idx] = (m_tbl[e.idx] == 3) ? 3 : m_tbl[e.idx] + 1;
          else            m_tbl[e.idx] = (m_tbl[e.idx] == 0) ? 0 : m_tbl[e.idx] - 1;
        end
        m_ghist = ((m_ghist * 2) + int'(rt)) % 16;
        if ((e.tk != rt) && (m_miss < 65535)) m_miss++;
      end
      if (fl) m_q.delete();
    end
    @(posedge clock);
    @(negedge clock);
    check("resp_valid",      int'(resp_valid),      int'(m_rv));
    check("resp_taken",      int'(resp_taken),      int'(m_rt));
    check("resp_use_global", int'(resp_use_global), int'(m_ug));
    check("ghist",           int'(ghist),           m_ghist);
    check("inflight_cnt",    int'(inflight_cnt),    m_q.size());
    check("mispredict_cnt",  int'(mispredict_cnt),  m_miss);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic req(input bit lp, input bit gp);
    step(0, 0, 1, lp, gp, 0, 0);
  endtask

  task automatic resolve(input bit rt);
    step(0, 0, 0, 0, 0, 1, rt);
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 1, 0);
    check("reset_ghist", int'(ghist), 0);
    check("reset_mispredict", int'(mispredict_cnt), 0);
    idle();

    // Local-preferred start, then train entry 0 toward global.
    req(1, 0);
    resolve(0);
    req(1, 0);
    resolve(0);
    req(1, 0);
    check("train_use_global", int'(resp_use_global), 1);
    check("train_taken", int'(resp_taken), 0);
    check("train_miss", int'(mispredict_cnt), 2);
    resolve(0);

    // Fill the queue; the fifth request must stall.
    repeat (5) req(1, 0);
    check("full_cnt", int'(inflight_cnt), DEPTH);
    resolve(1);
    idle();
    repeat (3) resolve(0);

    // Agreeing predictors leave the counter alone; request under a resolve stalls.
    req(1, 1);
    step(0, 0, 1, 0, 1, 1, 0);
    idle();

    // Flush with a concurrent resolve.
    repeat (3) req($urandom_range(1), $urandom_range(1));
    step(0, 1, 1, 1, 0, 1, 1);
    check("flush_cnt", int'(inflight_cnt), 0);
    idle();

    // Push history to all-ones and saturate that entry at STRONG_GLOBAL.
    repeat (8) begin
      req(0, 1);
      resolve(1);
    end
    repeat (3) req(1, 0);
    step(1, 0, 1, 1, 0, 1, 0);
    req(1, 0);
    check("post_reset_local", int'(resp_use_global), 0);
    resolve(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(299) == 0), ($urandom_range(24) == 0),
           $urandom_range(1), $urandom_range(1), $urandom_range(1),
           ($urandom_range(2) == 0), $urandom_range(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tournament_choice_ctrl.md
Name: tournament_choice_ctrl

Overview:
- Controller and scheduler for the choice side of the tournament predictor.
- Owns the table of 2-bit choice counters, indexed by a global history register, and picks the local or global prediction per branch.
- Tracks in-flight branches in an in-order queue and applies the choice update at resolve time.
- The table is single-ported: one access per cycle, shared between predict requests and resolve updates.

Parameters:
HIST_BITS, 4, global history width; choice table has 2**HIST_BITS entries
DEPTH, 4, in-flight queue depth (power of 2, at least 2)
CNT_W, 16, width of the saturating mispredict counter

Ports:
clock  in  1  single clock; all state changes on its rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  predict request
req_ready  out  1  request accepted when req_valid && req_ready
req_local_pred  in  1  local predictor's direction for this branch
req_global_pred  in  1  global predictor's direction for this branch
resp_valid  out  1  one-cycle pulse, cycle after acceptance
resp_taken  out  1  final predicted direction
resp_use_global  out  1  1 = global predictor chosen, 0 = local
res_valid  in  1  resolve of the oldest in-flight branch
res_ready  out  1  high when the queue is non-empty
res_taken  in  1  actual branch outcome
flush  in  1  discard all in-flight branches
ghist  out  HIST_BITS  committed global history
inflight_cnt  out  $clog2(DEPTH)+1  queue occupancy
mispredict_cnt  out  CNT_W  count of resolved branches whose final prediction != outcome, saturating

Behaviour:
- Reset (synchronous, sampled on clock edge):
  - all table entries = STRONG_LOCAL (0); queue emptied
  - ghist = 0, inflight_cnt = 0, mispredict_cnt = 0
  - resp_valid = 0, resp_taken = 0, resp_use_global = 0
  - req_ready = 0 and res_ready = 0 while reset is high
- Reset mid-operation drops all in-flight entries with no table update.
- Counter encoding: 0 STRONG_LOCAL, 1 WEAK_LOCAL, 2 WEAK_GLOBAL, 3 STRONG_GLOBAL. Global is chosen when counter[1] = 1.
- Arbitration, priority order: flush > resolve > request.
  - req_ready = !reset && !flush && !res_valid && (inflight_cnt != DEPTH)
  - A request in the same cycle as a resolve or flush is stalled, not dropped.
  - res_ready = !reset && (inflight_cnt != 0).
- Predict, accept cycle:
  - read table[ghist]; use_global = counter[1]
  - taken = use_global ? req_global_pred : req_local_pred
  - push {ghist, local_pred, global_pred, taken} into the queue
- Predict, next cycle: resp_valid = 1 with registered taken and use_global. Latency is exactly 1 cycle.
- Resolve, when res_valid && res_ready; pop the head entry:
  - if local_pred != global_pred: if global_pred == res_taken, saturating increment table[idx], else saturating decrement. Saturation holds at 3 and at 0.
  - if local_pred == global_pred: counter unchanged.
  - ghist <= {ghist[HIST_BITS-2:0], res_taken}. History is non-speculative and updated only at resolve.
  - if the entry's taken != res_taken: mispredict_cnt increments, saturating at all-ones.
- A resolve while the queue is empty (res_ready = 0) is ignored: no state change.
- Table write occurs at the resolve edge. A request in the following cycle reads the updated value; no bypass is needed because same-cycle collision is impossible.
- Flush:
  - queue emptied (inflight_cnt = 0) next cycle
  - no table, ghist or mispredict_cnt change, even if res_valid is high
  - resp_valid for a request accepted the previous cycle still fires
- Queue wrap-around: head and tail pointers wrap modulo DEPTH. Full and empty are distinguished by inflight_cnt.

Decomposition:
- Package tournament_pkg:
  - typedef enum logic [1:0] choice_e {STRONG_LOCAL, WEAK_LOCAL, WEAK_GLOBAL, STRONG_GLOBAL}
  - CHOICE_RESET = STRONG_LOCAL
  - struct inflight_t {idx, local_pred, global_pred, taken}
- Sub-module inflight_fifo: parameterised synchronous FIFO of inflight_t with push, pop, flush, count. Flush and reset empty it.
- Table, arbitration and counters stay in the top module.

Test Plan:
1. After reset, request local=1, global=0 -> next cycle resp_valid=1, resp_taken=1, resp_use_global=0; inflight_cnt=1.
2. Two request/resolve pairs with local=1, global=0, res_taken=0 -> table[0] goes 0→1→2, ghist stays 0. Third request -> resp_use_global=1, resp_taken=0. mispredict_cnt=2.
3. Four back-to-back requests -> inflight_cnt=4, req_ready=0 and a fifth req_valid is stalled. One resolve -> inflight_cnt=3, req_ready=1 the next cycle.
4. Request local=1, global=1 then resolve res_taken=0 -> table entry unchanged, mispredict_cnt +1, ghist shifts in 0. Same-cycle req_valid during res_valid -> req_ready=0.
5. Three in flight, assert flush together with res_valid=1 -> inflight_cnt=0, res_ready=0, table/ghist/mispredict_cnt unchanged.
6. Saturation and reset:
   - drive table[idx] to 3, resolve with global correct -> stays 3
   - assert reset with entries in flight -> all outputs return to reset values, table back to 0
